mac_result_drain: RTL
=====================

Name: mac_result_drain

Overview:
- Receiving end of the multi-lane MAC result interface: captures the 5 parallel 36-bit accumulator results (C bus plus per-lane valid mask) and buffers them as whole frames.
- Buffers up to DEPTH frames in a FIFO.
- Drains them one lane per beat over a ready/valid stream for writeback or host readout.
- Sits directly downstream of the multi-lane MAC array in the matrix datapath.

Parameters:
LANES, 5, number of MAC lanes per frame (max 8)
RW, 36, width of one lane result in bits
DEPTH, 4, FIFO depth in frames (power of two, >= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
C  in  LANES*RW  lane results; lane i at bits [i*RW +: RW]
valid  in  LANES  per-lane result strobe; bit i qualifies lane i for one cycle
dout  out  RW  current output lane value
dout_idx  out  3  lane index of dout (0..LANES-1)
dout_last  out  1  high on the beat with dout_idx == LANES-1
dout_valid  out  1  output beat valid
dout_ready  in  1  downstream accepts the beat
frame_cnt  out  16  count of frames fully drained, wraps at 2^16
overflow  out  1  sticky error flag

Behaviour:
- Reset (rst_n low at a clk edge): dout, dout_idx, dout_last, dout_valid, frame_cnt, overflow all 0. Capture mask and FIFO pointers are cleared. Reset mid-frame or mid-drain discards all partial and buffered data, with no output glitch beyond dropping dout_valid.
- Capture stage:
  - Per-lane hold register plus pending mask.
  - On an edge with valid[i]=1, lane i's hold register loads C lane i and pending[i] is set.
  - Lanes arrive in any order and over any number of cycles; they may be staggered.
  - Frame completes when (pending | valid) == all ones at an edge. That same edge writes the merged frame (incoming lanes take priority over held values) into the FIFO and clears pending.
  - valid[i]=1 while pending[i] is already set: overwrite the lane and set overflow.
- FIFO: DEPTH entries of LANES*RW bits.
  - Frame completes while the FIFO is full and no pop happens on that edge: the frame is dropped, overflow is set, and FIFO contents are unchanged.
  - Pop occurs on the acceptance of the dout_last beat.
  - Push and pop on the same edge with the FIFO full: both take effect, and the frame is accepted.
- Output FSM, states IDLE and SEND:
  - IDLE: when the FIFO is non-empty, load the head frame, set dout_idx=0, drive dout = lane 0, assert dout_valid, and go to SEND.
  - SEND: a beat is accepted when dout_valid && dout_ready.
    - Accepted with idx < LANES-1: idx increments and dout = next lane.
    - Accepted with idx == LANES-1: pop the FIFO and increment frame_cnt. If another frame is present (after the pop), reload with idx=0 and no bubble; otherwise go to IDLE and deassert dout_valid.
  - Stall: while dout_valid && !dout_ready, dout, dout_idx and dout_last hold stable.
- Latency: a frame completing at edge k gives dout_valid=1 after edge k+1 (FIFO was empty, FSM was in IDLE). Sustained throughput is 1 lane/cycle with dout_ready held high.
- overflow stays set until reset.
- frame_cnt wraps from 0xFFFF to 0.

Optional Feature:
MAC_DRAIN_SAT_EN
- Defined: dout is the lane value saturated to signed 32-bit range and sign-extended to RW. Values > 2^31-1 give 0x07FFFFFFF; values < -2^31 give 0xF80000000.
- Undefined: dout is the raw RW-bit lane value.
- Handshake and timing are identical in both builds.

Test Plan:
- Single frame: C lanes 0..4 = 8,28,36,12,20 with valid=5'b11111 for one cycle, dout_ready=1 -> dout_valid high one cycle later; beats 8,28,36,12,20 with idx 0..4; dout_last only on 20; frame_cnt=1.
- Staggered lanes: valid bit i asserted on cycle i (lane values 1..5) -> no output until lane 4 captured; then beats 1,2,3,4,5.
- Backpressure: two frames queued, dout_ready toggled 1,0,0,1... -> dout and dout_idx stable during stalls; all 10 beats delivered in order with no bubble between frames; frame_cnt=2.
- Full/overflow: dout_ready=0, push DEPTH+1 frames -> overflow=1 after the 5th completion; releasing ready drains exactly 4 frames. Also push on the edge where the last beat of a full FIFO is accepted -> accepted, overflow stays 0.
- Reset mid-drain: rst_n low for 1 cycle during beat idx 2 -> all outputs 0 and FIFO empty next cycle; a new frame afterwards drains normally from idx 0.
- MAC_DRAIN_SAT_EN build: lanes 0x100000000 and 0xE00000000 -> dout 0x07FFFFFFF and 0xF80000000. Non-macro build -> raw values.

Source files
------------

// File: rtl/mac_result_drain.sv
// MAC result drain: captures per-lane MAC results into whole frames, queues them, and streams them out one lane per beat.
// Optional build macro MAC_DRAIN_SAT_EN clamps each output lane to the signed 32-bit range.

module mac_drain_lane #(
  parameter int RW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] i_c,
  input  logic          i_valid,
  input  logic          i_clear,
  output logic          o_pend,
  output logic [RW-1:0] o_merged,
  output logic          o_dup
);
  logic [RW-1:0] r_hold;
  logic          r_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_pend <= 1'b0;
    end else begin
      if (i_valid) r_hold <= i_c;
      r_pend <= i_clear ? 1'b0 : (r_pend | i_valid);
    end
  end

  // a lane arriving on the completing edge bypasses its hold register
  assign o_merged = i_valid ? i_c : r_hold;
  assign o_pend   = r_pend;
  assign o_dup    = i_valid & r_pend;
endmodule

module mac_result_drain #(
  parameter int LANES = 5,
  parameter int RW    = 36,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES*RW-1:0] C,
  input  logic [LANES-1:0]    valid,
  output logic [RW-1:0]       dout,
  output logic [2:0]          dout_idx,
  output logic                dout_last,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [15:0]         frame_cnt,
  output logic                overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] LAST = 3'(LANES-1);

  typedef logic [LANES-1:0][RW-1:0] frame_t;
  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic [RW-1:0] f_sat(input logic [RW-1:0] v);
`ifdef MAC_DRAIN_SAT_EN
    if ((&v[RW-1:31]) || !(|v[RW-1:31])) return v;
    return v[RW-1] ? {{(RW-31){1'b1}}, 31'd0} : {{(RW-31){1'b0}}, {31{1'b1}}};
`else
    return v;
`endif
  endfunction

  // capture stage
  frame_t         w_merged;
  logic [LANES-1:0] w_pend, w_dup;
  logic           w_complete;

  assign w_complete = &(w_pend | valid);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_drain_lane #(.RW(RW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_c      (C[g*RW +: RW]),
      .i_valid  (valid[g]),
      .i_clear  (w_complete),
      .o_pend   (w_pend[g]),
      .o_merged (w_merged[g]),
      .o_dup    (w_dup[g])
    );
  end

  // frame FIFO
  frame_t        r_mem [DEPTH];
  logic [AW:0]   r_wr, r_rd, w_count;
  logic          w_full, w_empty, w_push, w_pop, w_drop;
  frame_t        w_head, w_next;

  assign w_count = r_wr - r_rd;
  assign w_full  = (w_count == (AW+1)'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_head  = r_mem[r_rd[AW-1:0]];
  assign w_next  = r_mem[r_rd[AW-1:0] + AW'(1)];

  // output FSM registers
  state_t       r_state, w_nstate;
  logic [2:0]   r_idx, w_nidx;
  logic         r_vld, w_nvld, w_ld;
  logic [RW-1:0] r_dout, w_lane;
  logic [15:0]  r_fcnt;
  logic         r_ovf;
  frame_t       w_src;

  assign w_pop  = (r_state == SEND) & r_vld & dout_ready & (r_idx == LAST);
  // a full FIFO still takes the frame when its head leaves on the same edge
  assign w_push = w_complete & (~w_full | w_pop);
  assign w_drop = w_complete & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_merged;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_nvld   = r_vld;
    w_ld     = 1'b0;
    w_src    = w_head;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_nstate = SEND;
          w_nidx   = '0;
          w_nvld   = 1'b1;
          w_ld     = 1'b1;
        end
      end
      SEND: begin
        if (r_vld && dout_ready) begin
          if (r_idx != LAST) begin
            w_nidx = r_idx + 3'd1;
            w_ld   = 1'b1;
          end else if ((w_count > (AW+1)'(1)) || w_push) begin
            // back-to-back frames: next head is either already stored or arriving now
            w_nidx = '0;
            w_ld   = 1'b1;
            w_src  = (w_count > (AW+1)'(1)) ? w_next : w_merged;
          end else begin
            w_nstate = IDLE;
            w_nidx   = '0;
            w_nvld   = 1'b0;
          end
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < LANES; i++)
      if (w_nidx == 3'(i)) w_lane = w_src[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_vld  <= 1'b0;
      r_dout <= '0;
      r_fcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_idx <= w_nidx;
      r_vld <= w_nvld;
      if (w_ld)  r_dout <= f_sat(w_lane);
      if (w_pop) r_fcnt <= r_fcnt + 16'd1;
      if ((|w_dup) || w_drop) r_ovf <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_idx   = r_idx;
  assign dout_valid = r_vld;
  assign dout_last  = r_vld & (r_idx == LAST);
  assign frame_cnt  = r_fcnt;
  assign overflow   = r_ovf;
endmodule
